// File: rtl/tm_result_collector.sv
// Result collector: captures one record per completed image into a FIFO for host readout,
// keeps image/correct counters, and pulses img_rst to re-arm the inference chain.
module tm_result_collector #(
    parameter int unsigned CLASSN     = 10,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 2,
    localparam int unsigned CW        = $clog2(CLASSN),
    localparam int unsigned RW        = 2 * CW + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             done,
    input  logic [CW-1:0]    class_op,
    input  logic             label_valid,
    input  logic [CW-1:0]    label,
    input  logic             clear,
    input  logic             rd_en,
    output logic [RW-1:0]    rd_data,
    output logic             rd_valid,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             overflow,
    output logic [CNT_W-1:0] img_count,
    output logic [CNT_W-1:0] correct_count,
    output logic             img_rst
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StRestart, StRearm} state_e;

    state_e           state_q, state_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic             done_q;
    logic             capture;

    logic             has_label_q;
    logic [CW-1:0]    slot_q;

    logic [AW:0]      wptr_q, rptr_q;
    logic [RW-1:0]    mem_q [DEPTH];
    logic [RW-1:0]    rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic [CNT_W-1:0] img_count_q, correct_count_q;

    logic             empty, full, pop, push, drop, match;
    logic [RW-1:0]    record;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (done && !done_q) begin
                    capture = 1'b1;
                    state_d = StRestart;
                    rcnt_d  = '0;
                end
            end
            StRestart: begin
                if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                    state_d = StRearm;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            StRearm: begin
                if (!done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Slot value is kept at zero while empty, so an unlabelled record carries label 0.
    assign match  = has_label_q && (slot_q == class_op);
    assign record = {has_label_q, match, slot_q, class_op};

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = rd_en && !empty && !clear;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign push  = capture && (!full || pop) && !clear;
    assign drop  = capture && full && !pop && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            rd_data_q       <= '0;
            rd_valid_q      <= 1'b0;
            overflow_q      <= 1'b0;
            img_count_q     <= '0;
            correct_count_q <= '0;
            has_label_q     <= 1'b0;
            slot_q          <= '0;
        end else if (clear) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            rd_valid_q      <= 1'b0;
            overflow_q      <= 1'b0;
            img_count_q     <= '0;
            correct_count_q <= '0;
            has_label_q     <= 1'b0;
            slot_q          <= '0;
        end else begin
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem_q[rptr_q[AW-1:0]];
                rptr_q    <= rptr_q + 1'b1;
            end
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (capture && (img_count_q != '1)) begin
                img_count_q <= img_count_q + 1'b1;
            end
            if (capture && match && (correct_count_q != '1)) begin
                correct_count_q <= correct_count_q + 1'b1;
            end
            // A same-edge strobe lands for the next image; the record uses the old slot.
            if (label_valid) begin
                has_label_q <= 1'b1;
                slot_q      <= label;
            end else if (capture) begin
                has_label_q <= 1'b0;
                slot_q      <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= record;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign fifo_empty    = empty;
    assign fifo_full     = full;
    assign overflow      = overflow_q;
    assign img_count     = img_count_q;
    assign correct_count = correct_count_q;
    assign img_rst       = (state_q == StRestart);

endmodule

// File: tb/tb_tm_result_collector.sv
// Bench for tm_result_collector: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_tm_result_collector;

    localparam int CW    = 4;
    localparam int RW    = 2 * CW + 2;
    localparam int DEPTH = 16;
    localparam int RSTC  = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             done;
    logic [CW-1:0]    class_op;
    logic             label_valid;
    logic [CW-1:0]    label;
    logic             clear;
    logic             rd_en;
    logic [RW-1:0]    rd_data;
    logic             rd_valid;
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow;
    logic [CNT_W-1:0] img_count;
    logic [CNT_W-1:0] correct_count;
    logic             img_rst;

    int checks = 0;
    int errors = 0;

    tm_result_collector #(
        .CLASSN    (10),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .RST_CYCLES(RSTC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .done         (done),
        .class_op     (class_op),
        .label_valid  (label_valid),
        .label        (label),
        .clear        (clear),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .img_count    (img_count),
        .correct_count(correct_count),
        .img_rst      (img_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results queue, counters, label slot, and a busy window per image.
    logic [RW-1:0] mq[$];
    bit            m_done_prev = 0;
    bit            m_has = 0;
    logic [CW-1:0] m_slot = '0;
    bit            m_ovf = 0;
    int            m_img = 0;
    int            m_cor = 0;
    int            m_left = 0;
    bit            m_wait = 0;
    bit            m_rdv = 0;
    logic [RW-1:0] m_rdd = '0;

    always @(posedge clk or negedge rst_n) begin : model
        bit            cap;
        bit            pop;
        bit            m;
        logic [RW-1:0] rec;
        if (!rst_n) begin
            mq.delete();
            m_done_prev = 0; m_has = 0; m_slot = '0; m_ovf = 0;
            m_img = 0; m_cor = 0; m_left = 0; m_wait = 0; m_rdv = 0; m_rdd = '0;
        end else begin
            cap = (m_left == 0) && !m_wait && done && !m_done_prev;
            m   = m_has && (m_slot == class_op);
            rec = {m_has, m, m_slot, class_op};
            if (clear) begin
                mq.delete();
                m_ovf = 0; m_img = 0; m_cor = 0; m_has = 0; m_slot = '0; m_rdv = 0;
            end else begin
                pop   = rd_en && (mq.size() > 0);
                m_rdv = pop;
                if (pop) m_rdd = mq.pop_front();
                if (cap) begin
                    if (mq.size() < DEPTH) mq.push_back(rec);
                    else m_ovf = 1;
                    if (m_img < 65535) m_img++;
                    if (m && m_cor < 65535) m_cor++;
                end
                if (label_valid) begin
                    m_slot = label; m_has = 1;
                end else if (cap) begin
                    m_slot = '0; m_has = 0;
                end
            end
            if (cap) begin
                m_left = RSTC;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_wait = 1;
            end else if (m_wait && !done) begin
                m_wait = 0;
            end
            m_done_prev = done;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
            chk("rd_data", 32'(rd_data), 32'(m_rdd));
            chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("img_count", 32'(img_count), 32'(m_img));
            chk("correct_count", 32'(correct_count), 32'(m_cor));
            chk("img_rst", 32'(img_rst), 32'(m_left > 0));
        end
    end

    task automatic strobe(input logic [CW-1:0] v);
        label = v; label_valid = 1'b1;
        @(negedge clk);
        label_valid = 1'b0;
    endtask

    task automatic image(input logic [CW-1:0] c);
        class_op = c; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; done = 1'b0; class_op = '0; label_valid = 1'b0; label = '0;
        clear = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset fifo_empty", 32'(fifo_empty), 32'd1);
        chk("reset fifo_full", 32'(fifo_full), 32'd0);
        chk("reset img_rst", 32'(img_rst), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset img_count", 32'(img_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Labelled, matching image
        strobe(4'd3);
        class_op = 4'd3; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("s1 img_count", 32'(img_count), 32'd1);
        chk("s1 correct_count", 32'(correct_count), 32'd1);
        chk("s1 fifo_empty", 32'(fifo_empty), 32'd0);
        chk("s1 img_rst c1", 32'(img_rst), 32'd1);
        @(negedge clk);
        chk("s1 img_rst c2", 32'(img_rst), 32'd1);
        @(negedge clk);
        chk("s1 img_rst c3", 32'(img_rst), 32'd0);
        repeat (2) @(negedge clk);
        pop_one();
        chk("s1 rd_valid", 32'(rd_valid), 32'd1);
        chk("s1 rd_data", 32'(rd_data), 32'h333);
        @(negedge clk);
        chk("s1 rd_valid drop", 32'(rd_valid), 32'd0);

        // Unlabelled image
        image(4'd5);
        pop_one();
        chk("s2 rd_data", 32'(rd_data), 32'h005);
        chk("s2 img_count", 32'(img_count), 32'd2);
        chk("s2 correct_count", 32'(correct_count), 32'd1);

        // Overfill
        do_clear();
        for (int i = 0; i < 17; i++) image(4'(i % 10));
        chk("s3 fifo_full", 32'(fifo_full), 32'd1);
        chk("s3 overflow", 32'(overflow), 32'd1);
        chk("s3 img_count", 32'(img_count), 32'd17);

        // Full FIFO, pop on the capture edge
        do_clear();
        for (int i = 0; i < 16; i++) image(4'((i % 9) + 1));
        chk("s4 full before", 32'(fifo_full), 32'd1);
        class_op = 4'd9; done = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        done = 1'b0; rd_en = 1'b0;
        chk("s4 rd_data", 32'(rd_data), 32'h001);
        chk("s4 fifo_full", 32'(fifo_full), 32'd1);
        chk("s4 overflow", 32'(overflow), 32'd0);
        chk("s4 img_count", 32'(img_count), 32'd17);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) pop_one();
        chk("s4 last rd_data", 32'(rd_data), 32'h009);
        chk("s4 drained", 32'(fifo_empty), 32'd1);

        // Done edges during the busy window are ignored
        do_clear();
        class_op = 4'd7; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        done = 1'b1; class_op = 4'd8;
        repeat (4) @(negedge clk);
        chk("s5 one image", 32'(img_count), 32'd1);
        done = 1'b0;
        @(negedge clk);
        done = 1'b1; class_op = 4'd6;
        @(negedge clk);
        done = 1'b0;
        chk("s5 second image", 32'(img_count), 32'd2);
        repeat (4) @(negedge clk);
        pop_one();
        chk("s5 rec1", 32'(rd_data), 32'h007);
        pop_one();
        chk("s5 rec2", 32'(rd_data), 32'h006);

        // Label strobe on the capture edge goes to the next image
        do_clear();
        strobe(4'd4);
        label = 4'd2; label_valid = 1'b1; class_op = 4'd4; done = 1'b1;
        @(negedge clk);
        label_valid = 1'b0; done = 1'b0;
        repeat (4) @(negedge clk);
        image(4'd2);
        pop_one();
        chk("s7 rec1", 32'(rd_data), 32'h344);
        pop_one();
        chk("s7 rec2", 32'(rd_data), 32'h322);
        chk("s7 correct_count", 32'(correct_count), 32'd2);

        // Clear with capture, then async reset mid-pulse
        image(4'd1);
        clear = 1'b1; done = 1'b1; class_op = 4'd3;
        @(negedge clk);
        clear = 1'b0; done = 1'b0;
        chk("s6 img_count", 32'(img_count), 32'd0);
        chk("s6 fifo_empty", 32'(fifo_empty), 32'd1);
        chk("s6 img_rst", 32'(img_rst), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6 img_rst async", 32'(img_rst), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("s6 post reset empty", 32'(fifo_empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
